icache_refill_arbiter: RTL and testbench
========================================

// Module: icache_refill_arbiter
// PURPOSE
//  Shares one instruction-memory refill port among N_REQ icache controllers (one per SM sub-partition).
//  Round-robin arbitration with one outstanding refill. Same-line merge: every requester missing on the
//  granted line address is answered from a single memory access. Sits between the icache miss ports
//  and the instr_mem backend.
// PARAMETERS
//  N_REQ      4   number of icache requesters (>=2)
//  ADDR_W     32  byte-address width
//  DATA_W     64  refill data width (one beat per refill)
//  LINE_BYTES 64  line size; low $clog2(LINE_BYTES) addr bits are ignored in merge compare
//  CNT_W      16  width of saturating statistics counters
// PORTS
//  clk         in   1             clock; all logic on posedge
//  rst_n       in   1             reset, synchronous, active-low
//  req         in   N_REQ         per-requester miss request, level, held until its ack
//  req_addr    in   N_REQ*ADDR_W  line address per requester, slice i = [i*ADDR_W +: ADDR_W]
//  req_ack     out  N_REQ         one-cycle pulse: refill data valid for requester i
//  req_rdata   out  DATA_W        refill data, broadcast, valid while any req_ack bit high
//  mem_req     out  1             backend request, level, held until mem_ack
//  mem_addr    out  ADDR_W        backend line address, stable while mem_req=1
//  mem_ack     in   1             backend one-cycle completion pulse
//  mem_rdata   in   DATA_W        backend data, valid with mem_ack
//  grant_cnt   out  CNT_W         refills issued to memory, saturating
//  merge_cnt   out  CNT_W         extra requesters served by merge, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, rr_ptr=0, mem_req=0, mem_addr=0, req_ack=0, req_rdata=0,
//   grant_cnt=0, merge_cnt=0. Reset mid-refill abandons it. Any later mem_ack is ignored.
//  FSM: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: if |req, winner w = first set bit searching from rr_ptr upward, with wrap modulo N_REQ.
//   Next edge: mem_req<=1, mem_addr<=req_addr[w] with offset bits cleared, owner<=w, grant_cnt++, ->BUSY.
//   mem_ack while in IDLE is ignored.
//  BUSY: mem_req/mem_addr held. On mem_ack, at the next edge:
//   - req_ack<=hitmask; hitmask = bit owner, plus every i!=owner with req[i]=1 and
//     line(req_addr[i])==line(mem_addr).
//   - req_rdata<=mem_rdata, mem_req<=0.
//   - merge_cnt += popcount(hitmask)-1, saturating.
//   - rr_ptr<=(owner+1)%N_REQ.
//   - ->RESP.
//  RESP: req_ack/req_rdata visible for exactly this one cycle. Next edge req_ack<=0 ->IDLE. No grant is
//   made in RESP. Acked requesters drop req on the same edge they see ack, so they are not re-granted.
//  Latency: IDLE with req -> mem_req 1 cycle; mem_ack -> req_ack 1 cycle; min 3 cycles per refill.
//  Owner drops req while BUSY: refill still completes and the owner bit is still acked (data discarded).
//   A non-owner that dropped req is not merged.
//  A requester changing req_addr while req=1 is illegal (assertion).
//  Merge compare uses addr[ADDR_W-1:$clog2(LINE_BYTES)] only.
//  Counters saturate at all-ones and never wrap.
//  At most one outstanding backend request. mem_req never rises in the cycle after it fell.
// STRUCTURE
//  Shared package sm_mem_pkg: typedef enum {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_e.
//   Also holds the line_addr() function (offset clear) for reuse by icache_controller and other mem arbiters.
//  Sub-module rr_pick #(N) (req, ptr -> onehot grant, index): combinational rotate-priority encoder.
//   Reusable by other SM arbiters.
//  Everything else (FSM, merge compare, counters) lives in this module.
// TESTING
//  1 Single: req=0001, addr0=0x1040 -> mem_req next cycle with mem_addr=0x1040; mem_ack with
//    rdata=0xDEAD -> req_ack=0001 and req_rdata=0xDEAD one cycle later; grant_cnt=1.
//  2 Round-robin: req=1111, distinct lines, each acked after 2 cycles -> grant order 0,1,2,3,0;
//    grant_cnt=5 and merge_cnt=0 after 5 refills.
//  3 Merge: req0 addr=0x2000, req2 addr=0x2038 (same line), req1 addr=0x3000 -> one mem_req at 0x2000;
//    ack gives req_ack=0101; next grant to 1; merge_cnt=1.
//  4 Reset mid-refill: rst_n=0 during BUSY -> all outputs 0 next edge; late mem_ack with rst_n=1 and
//    req=0 -> no req_ack, grant_cnt stays 0.
//  5 Owner abandon: owner 1 drops req in BUSY, req3 same line still high -> ack=1010; rr_ptr=2.
//  6 Saturation: preload via 65535 refills (or force) -> grant_cnt holds 0xFFFF after further grants.

Source files
------------

// File: rtl/sm_mem_pkg.sv
// Shared SM memory-path types and helpers.
// Used by the refill arbiter, icache_controller and the other memory arbiters.
package sm_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_e;

  // Clears the within-line offset bits; line_bytes must be a power of two.
  function automatic logic [63:0] line_addr(input logic [63:0] addr,
                                            input int unsigned line_bytes);
    logic [63:0] mask;
    mask = 64'(line_bytes) - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder.
// Returns the first set request at or above ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    int unsigned j;
    j       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/icache_refill_arbiter.sv
// Shares one instruction-memory refill port among N_REQ icache controllers.
// Round-robin, one refill outstanding, same-line requesters served by a single access.
module icache_refill_arbiter
  import sm_mem_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  output logic [N_REQ-1:0]        req_ack_o,
  output logic [DATA_W-1:0]       req_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  input  logic                    mem_ack_i,
  input  logic [DATA_W-1:0]       mem_rdata_i,
  output logic [CNT_W-1:0]        grant_cnt_o,
  output logic [CNT_W-1:0]        merge_cnt_o
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned PopW = $clog2(N_REQ + 1);
  localparam int unsigned SumW = CNT_W + 1;

  function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return ADDR_W'(line_addr(64'(a), LINE_BYTES));
  endfunction

  arb_state_e          state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d, owner_q, owner_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    grant_cnt_q, grant_cnt_d, merge_cnt_q, merge_cnt_d;

  logic [ADDR_W-1:0]   addr_arr [N_REQ];
  logic [N_REQ-1:0]    pick_gnt, hit_mask;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_valid;
  logic [PopW-1:0]     hit_cnt;
  logic [SumW-1:0]     merge_sum;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
    assign addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
    a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_i[gi] && $past(req_i[gi])) |-> (addr_arr[gi] == $past(addr_arr[gi])));
  end

  rr_pick #(
    .N(N_REQ)
  ) u_rr_pick (
    .req_i  (req_i),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );

  // Owner is always acked, even if it dropped req mid-refill; others only if still asking.
  always_comb begin
    hit_mask = '0;
    hit_cnt  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IdxW'(i) == owner_q) begin
        hit_mask[i] = 1'b1;
      end else if (req_i[i] && (line_of(addr_arr[i]) == mem_addr_q)) begin
        hit_mask[i] = 1'b1;
      end
      hit_cnt = hit_cnt + PopW'(hit_mask[i]);
    end
  end

  assign merge_sum = {1'b0, merge_cnt_q} + SumW'(hit_cnt) - SumW'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ARB_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (pick_valid) state_d = ARB_BUSY;
      ARB_BUSY: if (mem_ack_i)  state_d = ARB_RESP;
      ARB_RESP:                 state_d = ARB_IDLE;
      default:                  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    grant_cnt_d = grant_cnt_q;
    merge_cnt_d = merge_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          mem_req_d  = 1'b1;
          mem_addr_d = line_of(addr_arr[pick_idx]);
          owner_d    = pick_idx;
          if (grant_cnt_q != '1) grant_cnt_d = grant_cnt_q + 1'b1;
        end
      end
      ARB_BUSY: begin
        if (mem_ack_i) begin
          ack_d       = hit_mask;
          rdata_d     = mem_rdata_i;
          mem_req_d   = 1'b0;
          merge_cnt_d = merge_sum[CNT_W] ? '1 : merge_sum[CNT_W-1:0];
          rr_ptr_d    = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      grant_cnt_q <= '0;
      merge_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      grant_cnt_q <= grant_cnt_d;
      merge_cnt_q <= merge_cnt_d;
    end
  end

  assign req_ack_o   = ack_q;
  assign req_rdata_o = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign grant_cnt_o = grant_cnt_q;
  assign merge_cnt_o = merge_cnt_q;

endmodule

// File: tb/tb_icache_refill_arbiter.sv
// Self-checking bench for icache_refill_arbiter with an expected-refill scoreboard.
// A second small-counter instance exercises counter saturation.
module tb_icache_refill_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  ack;
    logic [63:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [127:0] req_addr = '0;
  logic [3:0]   req_ack;
  logic [63:0]  req_rdata;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack = 1'b0;
  logic [63:0]  mem_rdata = '0;
  logic [15:0]  grant_cnt, merge_cnt;

  logic         s_rst_n = 1'b0;
  logic [3:0]   s_req = '0;
  logic [127:0] s_req_addr = '0;
  logic [3:0]   s_req_ack;
  logic [63:0]  s_req_rdata;
  logic         s_mem_req;
  logic [31:0]  s_mem_addr;
  logic         s_mem_ack = 1'b0;
  logic [3:0]   s_grant_cnt, s_merge_cnt;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  icache_refill_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_addr_i(req_addr),
    .req_ack_o(req_ack), .req_rdata_o(req_rdata), .mem_req_o(mem_req),
    .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .grant_cnt_o(grant_cnt), .merge_cnt_o(merge_cnt)
  );

  icache_refill_arbiter #(.CNT_W(4)) dut_s (
    .clk_i(clk), .rst_ni(s_rst_n), .req_i(s_req), .req_addr_i(s_req_addr),
    .req_ack_o(s_req_ack), .req_rdata_o(s_req_rdata), .mem_req_o(s_mem_req),
    .mem_addr_o(s_mem_addr), .mem_ack_i(s_mem_ack), .mem_rdata_i(64'h5A5A),
    .grant_cnt_o(s_grant_cnt), .merge_cnt_o(s_merge_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [31:0] a);
    req_addr[i*32 +: 32] = a;
  endtask

  task automatic reset_dut();
    req = '0;
    mem_ack = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // Backend model: waits for mem_req, acks after 'delay' cycles, returns what the DUT did.
  task automatic do_refill(input int delay, input logic [63:0] data, output logic [31:0] a,
                           output logic [3:0] ack, output logic [63:0] rd, output bit to);
    to = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (mem_req) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    a   = mem_addr;
    ack = '0;
    rd  = '0;
    if (to) return;
    repeat (delay) tick();
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    ack = req_ack;
    rd  = req_rdata;
    req = req & ~ack;
  endtask

  task automatic test_reset();
    req = '0;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++;
      $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++;
      $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_checks++; if (req_ack !== 4'h0) begin n_fail++;
      $display("FAIL reset_req_ack: got %b expected 0", req_ack); end
    n_checks++; if (req_rdata !== 64'h0) begin n_fail++;
      $display("FAIL reset_req_rdata: got %h expected 0", req_rdata); end
    n_checks++; if (grant_cnt !== 16'h0 || merge_cnt !== 16'h0) begin n_fail++;
      $display("FAIL reset_counters: got %h/%h expected 0/0", grant_cnt, merge_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [31:0] a; logic [3:0] ack; logic [63:0] rd; bit to; exp_t e;
    reset_dut();
    set_addr(0, 32'h1040);
    set_addr(1, 32'h9000);
    exp_q.push_back('{addr: 32'h1040, ack: 4'b0001, data: 64'hDEAD});
    req = 4'b0001;
    tick();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++;
      $display("FAIL single_latency: mem_req got %b expected 1", mem_req); end
    do_refill(0, 64'hDEAD, a, ack, rd, to);
    e = exp_q.pop_front();
    n_checks++; if (to || a !== e.addr) begin n_fail++;
      $display("FAIL single_addr: got %h expected %h timeout=%0d", a, e.addr, to); end
    n_checks++; if (ack !== e.ack) begin n_fail++;
      $display("FAIL single_ack: got %b expected %b", ack, e.ack); end
    n_checks++; if (rd !== e.data) begin n_fail++;
      $display("FAIL single_rdata: got %h expected %h", rd, e.data); end
    tick();
    n_checks++; if (req_ack !== 4'h0) begin n_fail++;
      $display("FAIL single_ack_pulse: got %b expected 0", req_ack); end
    n_checks++; if (grant_cnt !== 16'd1 || merge_cnt !== 16'd0) begin n_fail++;
      $display("FAIL single_counters: got %0d/%0d expected 1/0", grant_cnt, merge_cnt); end
  endtask

  task automatic test_round_robin();
    logic [31:0] a; logic [3:0] ack; logic [63:0] rd; bit to; exp_t e;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      set_addr(i, 32'h4000 + 32'(i) * 32'h100);
      exp_q.push_back('{addr: 32'h4000 + 32'(i) * 32'h100, ack: 4'(1 << i),
                        data: 64'h100 + 64'(i)});
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        set_addr(0, 32'h5000);
        exp_q.push_back('{addr: 32'h5000, ack: 4'b0001, data: 64'h104});
        req = 4'b0001;
      end
      do_refill(2, 64'h100 + 64'(k), a, ack, rd, to);
      e = exp_q.pop_front();
      n_checks++; if (to || a !== e.addr) begin n_fail++;
        $display("FAIL rr_addr[%0d]: got %h expected %h timeout=%0d", k, a, e.addr, to); end
      n_checks++; if (ack !== e.ack) begin n_fail++;
        $display("FAIL rr_ack[%0d]: got %b expected %b", k, ack, e.ack); end
      n_checks++; if (rd !== e.data) begin n_fail++;
        $display("FAIL rr_rdata[%0d]: got %h expected %h", k, rd, e.data); end
    end
    n_checks++; if (grant_cnt !== 16'd5 || merge_cnt !== 16'd0) begin n_fail++;
      $display("FAIL rr_counters: got %0d/%0d expected 5/0", grant_cnt, merge_cnt); end
  endtask

  task automatic test_merge();
    logic [31:0] a; logic [3:0] ack; logic [63:0] rd; bit to; exp_t e;
    reset_dut();
    set_addr(0, 32'h2000);
    set_addr(1, 32'h3000);
    set_addr(2, 32'h2038);
    set_addr(3, 32'h7777_0000);
    exp_q.push_back('{addr: 32'h2000, ack: 4'b0101, data: 64'hA1});
    exp_q.push_back('{addr: 32'h3000, ack: 4'b0010, data: 64'hA2});
    req = 4'b0111;
    for (int k = 0; k < 2; k++) begin
      do_refill(1, 64'hA1 + 64'(k), a, ack, rd, to);
      e = exp_q.pop_front();
      n_checks++; if (to || a !== e.addr) begin n_fail++;
        $display("FAIL merge_addr[%0d]: got %h expected %h timeout=%0d", k, a, e.addr, to); end
      n_checks++; if (ack !== e.ack) begin n_fail++;
        $display("FAIL merge_ack[%0d]: got %b expected %b", k, ack, e.ack); end
      n_checks++; if (rd !== e.data) begin n_fail++;
        $display("FAIL merge_rdata[%0d]: got %h expected %h", k, rd, e.data); end
    end
    n_checks++; if (grant_cnt !== 16'd2 || merge_cnt !== 16'd1) begin n_fail++;
      $display("FAIL merge_counters: got %0d/%0d expected 2/1", grant_cnt, merge_cnt); end
  endtask

  task automatic test_reset_mid_refill();
    reset_dut();
    set_addr(0, 32'h6000);
    req = 4'b0001;
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h6000) begin n_fail++;
      $display("FAIL midrst_busy: got %b/%h expected 1/00006000", mem_req, mem_addr); end
    rst_n = 1'b0;
    req = '0;
    tick();
    n_checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || grant_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL midrst_clear: got %b/%h/%0d expected 0/0/0", mem_req, mem_addr, grant_cnt);
    end
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b1;
    mem_rdata = 64'hBAD;
    tick();
    mem_ack = 1'b0;
    n_checks++; if (req_ack !== 4'h0 || req_rdata !== 64'h0) begin n_fail++;
      $display("FAIL midrst_late_ack: got %b/%h expected 0/0", req_ack, req_rdata); end
    tick();
    n_checks++; if (grant_cnt !== 16'h0 || mem_req !== 1'b0 || req_ack !== 4'h0) begin
      n_fail++;
      $display("FAIL midrst_idle: got %0d/%b/%b expected 0/0/0", grant_cnt, mem_req, req_ack);
    end
  endtask

  task automatic test_owner_abandon();
    logic [31:0] a; logic [3:0] ack; logic [63:0] rd; bit to; exp_t e;
    reset_dut();
    set_addr(0, 32'h8000);
    set_addr(1, 32'h7000);
    set_addr(2, 32'h9000);
    set_addr(3, 32'h7010);
    exp_q.push_back('{addr: 32'h7000, ack: 4'b1010, data: 64'hC1});
    exp_q.push_back('{addr: 32'h9000, ack: 4'b0100, data: 64'hC2});
    req = 4'b1010;
    tick();
    req = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      do_refill(1, 64'hC1 + 64'(k), a, ack, rd, to);
      if (k == 0) req = req | 4'b0101;
      e = exp_q.pop_front();
      n_checks++; if (to || a !== e.addr) begin n_fail++;
        $display("FAIL abandon_addr[%0d]: got %h expected %h timeout=%0d", k, a, e.addr, to); end
      n_checks++; if (ack !== e.ack) begin n_fail++;
        $display("FAIL abandon_ack[%0d]: got %b expected %b", k, ack, e.ack); end
      n_checks++; if (rd !== e.data) begin n_fail++;
        $display("FAIL abandon_rdata[%0d]: got %h expected %h", k, rd, e.data); end
    end
    n_checks++; if (merge_cnt !== 16'd1) begin n_fail++;
      $display("FAIL abandon_merge_cnt: got %0d expected 1", merge_cnt); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) s_req_addr[i*32 +: 32] = 32'hA000 + 32'(i) * 32'h8;
    s_req = 4'b1111;
    s_mem_ack = 1'b1;
    s_rst_n = 1'b1;
    tick();
    n_checks++; if (s_grant_cnt !== 4'd1 || s_mem_addr !== 32'hA000) begin n_fail++;
      $display("FAIL sat_first: got %0d/%h expected 1/0000a000", s_grant_cnt, s_mem_addr); end
    tick();
    n_checks++; if (s_merge_cnt !== 4'd3 || s_req_ack !== 4'b1111) begin n_fail++;
      $display("FAIL sat_merge3: got %0d/%b expected 3/1111", s_merge_cnt, s_req_ack); end
    repeat (60) tick();
    n_checks++; if (s_grant_cnt !== 4'hF || s_merge_cnt !== 4'hF) begin n_fail++;
      $display("FAIL sat_hold1: got %h/%h expected f/f", s_grant_cnt, s_merge_cnt); end
    repeat (31) tick();
    n_checks++; if (s_grant_cnt !== 4'hF || s_merge_cnt !== 4'hF) begin n_fail++;
      $display("FAIL sat_hold2: got %h/%h expected f/f", s_grant_cnt, s_merge_cnt); end
    s_mem_ack = 1'b0;
    s_req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_merge();
    test_reset_mid_refill();
    test_owner_abandon();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
